// File: rtl/i2s_pkg.sv
// Shared constants and FSM encoding for the I2S capture path.
package i2s_pkg;

    localparam int WORD_BITS      = 16;
    localparam int BYTES_PER_WORD = WORD_BITS / 8;
    localparam int ADDR_W         = 9;
    localparam int BITCNT_W       = $clog2(WORD_BITS + 1);
    localparam int FILL_W         = $clog2(BYTES_PER_WORD + 1);

    typedef enum logic [1:0] {
        HUNT  = 2'd0,
        ARM   = 2'd1,
        SHIFT = 2'd2,
        DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/i2s_rx_sync.sv
// Synchronises BCLK/LRCLK/SDATA into iclk and flags BCLK rising edges.
// All three lines see the same pipeline depth, so lrclk/data line up with the rise.
module i2s_rx_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic iclk,
    input  logic rst_n,
    input  logic bclk_i,
    input  logic lrclk_i,
    input  logic data_i,
    output logic bclk_rise_o,
    output logic s_lrclk_o,
    output logic s_data_o
);

    logic [SYNC_STAGES-1:0] bclk_q;
    logic [SYNC_STAGES-1:0] lrclk_q;
    logic [SYNC_STAGES-1:0] data_q;
    logic                   bclk_prev_q;

    always_ff @(posedge iclk) begin
        if (!rst_n) begin
            bclk_q      <= '0;
            lrclk_q     <= '0;
            data_q      <= '0;
            bclk_prev_q <= 1'b0;
        end else begin
            bclk_q      <= {bclk_q[SYNC_STAGES-2:0], bclk_i};
            lrclk_q     <= {lrclk_q[SYNC_STAGES-2:0], lrclk_i};
            data_q      <= {data_q[SYNC_STAGES-2:0], data_i};
            bclk_prev_q <= bclk_q[SYNC_STAGES-1];
        end
    end

    assign bclk_rise_o = bclk_q[SYNC_STAGES-1] & ~bclk_prev_q;
    assign s_lrclk_o   = lrclk_q[SYNC_STAGES-1];
    assign s_data_o    = data_q[SYNC_STAGES-1];

endmodule

// File: rtl/i2s_rx.sv
// I2S slave receiver: deserialises each channel word MSB-first and emits it
// as byte writes (high byte first) into a circular byte buffer.
module i2s_rx
    import i2s_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic              iclk,
    input  logic              rst_n,
    input  logic              en,
    input  logic              i2s_bclk,
    input  logic              i2s_lrclk,
    input  logic              i2s_data,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [7:0]        wr_data,
    output logic              wr_sel,
    output logic              wr_right,
    output logic              frame_err,
    output logic [1:0]        dbg_state_o
);

    localparam logic [BITCNT_W-1:0] LAST_BIT = BITCNT_W'(WORD_BITS - 1);
    localparam logic [BITCNT_W-1:0] FULL_CNT = BITCNT_W'(WORD_BITS);

    logic bclk_rise;
    logic s_lrclk;
    logic s_data;

    i2s_rx_sync #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync (
        .iclk        (iclk),
        .rst_n       (rst_n),
        .bclk_i      (i2s_bclk),
        .lrclk_i     (i2s_lrclk),
        .data_i      (i2s_data),
        .bclk_rise_o (bclk_rise),
        .s_lrclk_o   (s_lrclk),
        .s_data_o    (s_data)
    );

    state_t              state_q,     state_d;
    logic [BITCNT_W-1:0] bitcnt_q,    bitcnt_d;
    logic [6:0]          sreg_q,      sreg_d;
    logic                chan_q,      chan_d;
    logic [ADDR_W-1:0]   addr_q,      addr_d;
    logic                wr_en_q,     wr_en_d;
    logic [7:0]          wr_data_q,   wr_data_d;
    logic                wr_right_q,  wr_right_d;
    logic                ferr_q,      ferr_d;
    logic [FILL_W-1:0]   fill_cnt_q,  fill_cnt_d;
    logic                fill_chan_q, fill_chan_d;
    logic                lr_prev_q,   lr_prev_d;
    logic                lr_valid_q,  lr_valid_d;

    logic                lr_edge;
    logic [BITCNT_W-1:0] bitcnt_inc;
    logic [7:0]          sreg_next;
    logic [FILL_W-1:0]   fill_total;

    // lr_valid_q keeps the very first rise after reset from posing as an LR edge.
    assign lr_edge    = bclk_rise & lr_valid_q & (s_lrclk != lr_prev_q);
    assign bitcnt_inc = bitcnt_q + BITCNT_W'(1);
    assign sreg_next  = {sreg_q, s_data};
    assign fill_total = FILL_W'(BYTES_PER_WORD) - FILL_W'(bitcnt_q >> 3);

    always_comb begin
        state_d     = state_q;
        bitcnt_d    = bitcnt_q;
        sreg_d      = sreg_q;
        chan_d      = chan_q;
        addr_d      = addr_q;
        wr_en_d     = 1'b0;
        wr_data_d   = wr_data_q;
        wr_right_d  = wr_right_q;
        ferr_d      = 1'b0;
        fill_cnt_d  = fill_cnt_q;
        fill_chan_d = fill_chan_q;
        lr_prev_d   = lr_prev_q;
        lr_valid_d  = lr_valid_q;

        if (bclk_rise) begin
            lr_prev_d  = s_lrclk;
            lr_valid_d = 1'b1;
        end

        if (wr_en_q) begin
            addr_d = addr_q + ADDR_W'(1);
        end

        if (fill_cnt_q != '0) begin
            wr_en_d    = 1'b1;
            wr_data_d  = 8'h00;
            wr_right_d = fill_chan_q;
            fill_cnt_d = fill_cnt_q - FILL_W'(1);
        end

        if (!en) begin
            state_d    = HUNT;
            wr_en_d    = 1'b0;
            fill_cnt_d = '0;
        end else begin
            case (state_q)
                HUNT, DONE: begin
                    if (lr_edge) begin
                        state_d  = ARM;
                        chan_d   = s_lrclk;
                        bitcnt_d = '0;
                    end
                end
                ARM, SHIFT: begin
                    if (bclk_rise) begin
                        if (lr_edge && bitcnt_q != LAST_BIT) begin
                            // Short word: first filler byte now, the rest one per iclk.
                            ferr_d      = 1'b1;
                            wr_en_d     = 1'b1;
                            wr_data_d   = 8'h00;
                            wr_right_d  = chan_q;
                            fill_cnt_d  = fill_total - FILL_W'(1);
                            fill_chan_d = chan_q;
                            state_d     = ARM;
                            chan_d      = s_lrclk;
                            bitcnt_d    = '0;
                        end else begin
                            sreg_d   = sreg_next[6:0];
                            bitcnt_d = bitcnt_inc;
                            state_d  = SHIFT;
                            if (bitcnt_inc[2:0] == 3'd0) begin
                                wr_en_d    = 1'b1;
                                wr_data_d  = sreg_next;
                                wr_right_d = chan_q;
                            end
                            if (bitcnt_inc == FULL_CNT) begin
                                state_d = DONE;
                            end
                            // LSB arriving on the LR edge itself (no BCLK gap).
                            if (lr_edge) begin
                                state_d  = ARM;
                                chan_d   = s_lrclk;
                                bitcnt_d = '0;
                            end
                        end
                    end
                end
                default: state_d = HUNT;
            endcase
        end
    end

    always_ff @(posedge iclk) begin
        if (!rst_n) begin
            state_q     <= HUNT;
            bitcnt_q    <= '0;
            sreg_q      <= '0;
            chan_q      <= 1'b0;
            addr_q      <= '0;
            wr_en_q     <= 1'b0;
            wr_data_q   <= '0;
            wr_right_q  <= 1'b0;
            ferr_q      <= 1'b0;
            fill_cnt_q  <= '0;
            fill_chan_q <= 1'b0;
            lr_prev_q   <= 1'b0;
            lr_valid_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            bitcnt_q    <= bitcnt_d;
            sreg_q      <= sreg_d;
            chan_q      <= chan_d;
            addr_q      <= addr_d;
            wr_en_q     <= wr_en_d;
            wr_data_q   <= wr_data_d;
            wr_right_q  <= wr_right_d;
            ferr_q      <= ferr_d;
            fill_cnt_q  <= fill_cnt_d;
            fill_chan_q <= fill_chan_d;
            lr_prev_q   <= lr_prev_d;
            lr_valid_q  <= lr_valid_d;
        end
    end

    assign wr_en       = wr_en_q;
    assign wr_addr     = addr_q;
    assign wr_data     = wr_data_q;
    assign wr_right    = wr_right_q;
    assign wr_sel      = wr_en_q & (addr_q == '1);
    assign frame_err   = ferr_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_i2s_rx.sv
// Bench for i2s_rx: drives I2S frames at 4 iclk per BCLK and checks every byte
// write against an expected queue filled as words are sent.
module tb_i2s_rx;
    import i2s_pkg::*;

    localparam int EW = ADDR_W + 10;

    logic              iclk = 1'b0;
    logic              rst_n = 1'b0;
    logic              en = 1'b0;
    logic              i2s_bclk = 1'b0;
    logic              i2s_lrclk = 1'b0;
    logic              i2s_data = 1'b0;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [7:0]        wr_data;
    logic              wr_sel;
    logic              wr_right;
    logic              frame_err;
    logic [1:0]        dbg_state;

    logic [EW-1:0]     exp_q[$];
    logic [EW-1:0]     mon_exp;
    logic [ADDR_W-1:0] exp_addr = '0;
    int                n_checks = 0;
    int                n_pass = 0;
    int                ferr_cnt = 0;

    // ---------------- clock / reset ----------------
    always #5 iclk = ~iclk;

    initial begin
        #900000;
        $display("FAIL watchdog: simulation exceeded 90000 iclk cycles, required completion");
        $fatal(1);
    end

    i2s_rx dut (
        .iclk        (iclk),
        .rst_n       (rst_n),
        .en          (en),
        .i2s_bclk    (i2s_bclk),
        .i2s_lrclk   (i2s_lrclk),
        .i2s_data    (i2s_data),
        .wr_en       (wr_en),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .wr_sel      (wr_sel),
        .wr_right    (wr_right),
        .frame_err   (frame_err),
        .dbg_state_o (dbg_state)
    );

    // ---------------- scoreboard ----------------
    always @(negedge iclk) begin
        if (frame_err === 1'b1) ferr_cnt++;
        if (wr_en === 1'b1) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                $display("FAIL unexpected_write: addr=%0d data=%02h right=%0b, required no write",
                         wr_addr, wr_data, wr_right);
            end else begin
                mon_exp = exp_q.pop_front();
                if ({wr_addr, wr_data, wr_right, wr_sel} !== mon_exp)
                    $display("FAIL write: got addr=%0d data=%02h right=%0b sel=%0b, required addr=%0d data=%02h right=%0b sel=%0b",
                             wr_addr, wr_data, wr_right, wr_sel,
                             mon_exp[EW-1:10], mon_exp[9:2], mon_exp[1], mon_exp[0]);
                else
                    n_pass++;
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic push_byte(input logic lr, input logic [7:0] b);
        exp_q.push_back({exp_addr, b, lr, (exp_addr == '1)});
        exp_addr = exp_addr + 1'b1;
    endtask

    task automatic push_word(input logic lr, input logic [15:0] w);
        push_byte(lr, w[15:8]);
        push_byte(lr, w[7:0]);
    endtask

    task automatic bit_out(input logic lr, input logic d);
        i2s_bclk  = 1'b0;
        i2s_lrclk = lr;
        i2s_data  = d;
        repeat (2) @(negedge iclk);
        i2s_bclk = 1'b1;
        repeat (2) @(negedge iclk);
    endtask

    // Slot: delay bit, nbits data bits MSB first, one pad bit when the word is complete.
    task automatic send_half(input logic lr, input logic [15:0] w, input int nbits);
        bit_out(lr, 1'b0);
        for (int i = 0; i < nbits; i++) bit_out(lr, w[15-i]);
        if (nbits == 16) bit_out(lr, 1'b0);
    endtask

    task automatic do_reset();
        i2s_bclk = 1'b0;
        i2s_data = 1'b0;
        repeat (2) @(negedge iclk);
        rst_n = 1'b0;
        en    = 1'b1;
        repeat (3) @(negedge iclk);
        rst_n = 1'b1;
        exp_q.delete();
        exp_addr = '0;
        ferr_cnt = 0;
        @(negedge iclk);
    endtask

    task automatic drain(input string name);
        int k;
        k = 0;
        while (exp_q.size() != 0 && k < 40) begin
            @(negedge iclk);
            k++;
        end
        repeat (6) @(negedge iclk);
        n_checks++;
        if (exp_q.size() != 0)
            $display("FAIL %s_drain: %0d writes outstanding, required 0", name, exp_q.size());
        else
            n_pass++;
    endtask

    task automatic check_ferr(input string name, input int expected);
        n_checks++;
        if (ferr_cnt !== expected)
            $display("FAIL %s_frame_err: got %0d pulse cycles, required %0d", name, ferr_cnt, expected);
        else
            n_pass++;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst_n = 1'b0;
        en    = 1'b0;
        repeat (3) @(negedge iclk);
        n_checks++;
        if ({wr_en, wr_addr, wr_data, wr_sel, wr_right, frame_err, dbg_state} !== '0)
            $display("FAIL reset_outputs: got en=%0b addr=%0d data=%02h sel=%0b right=%0b ferr=%0b state=%0d, required all 0",
                     wr_en, wr_addr, wr_data, wr_sel, wr_right, frame_err, dbg_state);
        else
            n_pass++;
    endtask

    task automatic test_single_frame();
        do_reset();
        send_half(1'b1, 16'h0F0F, 16);
        push_word(1'b0, 16'hA55A);
        send_half(1'b0, 16'hA55A, 16);
        push_word(1'b1, 16'h1234);
        send_half(1'b1, 16'h1234, 16);
        drain("single");
        check_ferr("single", 0);
        n_checks++;
        if (wr_addr !== 9'd4) $display("FAIL single_addr: got %0d, required 4", wr_addr);
        else n_pass++;
    endtask

    // Two passes of a 0x00..0xFF byte ramp; the first word precedes any LR edge.
    task automatic test_loopback();
        logic [15:0] w;
        do_reset();
        for (int i = 0; i < 256; i++) begin
            w = {8'(2 * i), 8'(2 * i + 1)};
            if (i != 0) push_word(i[0], w);
            send_half(i[0], w, 16);
        end
        drain("loopback");
        check_ferr("loopback", 0);
        n_checks++;
        if (wr_addr !== 9'd510) $display("FAIL loopback_addr: got %0d, required 510", wr_addr);
        else n_pass++;
    endtask

    task automatic test_wrap();
        push_word(1'b0, 16'hBEEF);
        send_half(1'b0, 16'hBEEF, 16);
        push_word(1'b1, 16'hC001);
        send_half(1'b1, 16'hC001, 16);
        drain("wrap");
        n_checks++;
        if (wr_addr !== 9'd2) $display("FAIL wrap_addr: got %0d, required 2", wr_addr);
        else n_pass++;
    endtask

    task automatic test_short_word();
        logic [15:0] w;
        int          nb;
        do_reset();
        send_half(1'b1, 16'h0000, 16);
        for (int k = 0; k < 4; k++) begin
            nb = (k == 0) ? 11 : int'($urandom_range(1, 14));
            w  = (k == 0) ? 16'hFFFF : 16'($urandom);
            push_byte(k[0], (nb >= 8) ? w[15:8] : 8'h00);
            push_byte(k[0], 8'h00);
            send_half(k[0], w, nb);
        end
        push_word(1'b0, 16'h5AA5);
        send_half(1'b0, 16'h5AA5, 16);
        drain("short");
        check_ferr("short", 4);
    endtask

    // 16 BCLKs per slot: each word's LSB rides on the next slot's LR edge.
    task automatic test_tight_frames();
        logic [15:0] w;
        logic        lsb;
        do_reset();
        lsb = 1'b0;
        for (int k = 0; k < 5; k++) begin
            w = 16'($urandom);
            if (k != 0) push_word(k[0], w);
            bit_out(k[0], lsb);
            for (int i = 15; i >= 1; i--) bit_out(k[0], w[i]);
            lsb = w[0];
        end
        bit_out(1'b1, lsb);
        drain("tight");
        check_ferr("tight", 0);
    endtask

    task automatic test_enable();
        logic [15:0] w;
        do_reset();
        send_half(1'b1, 16'h0000, 16);
        w = 16'($urandom);
        push_word(1'b0, w);
        send_half(1'b0, w, 16);
        w = 16'($urandom);
        push_word(1'b1, w);
        send_half(1'b1, w, 16);
        send_half(1'b0, 16'hFFFF, 5);
        en = 1'b0;
        for (int k = 0; k < 6; k++) send_half(~k[0], 16'($urandom), 16);
        en = 1'b1;
        repeat (2) @(negedge iclk);
        w = 16'($urandom);
        push_word(1'b1, w);
        send_half(1'b1, w, 16);
        w = 16'($urandom);
        push_word(1'b0, w);
        send_half(1'b0, w, 16);
        drain("enable");
        check_ferr("enable", 0);
        n_checks++;
        if (wr_addr !== 9'd8) $display("FAIL enable_addr: got %0d, required 8", wr_addr);
        else n_pass++;
    endtask

    task automatic test_reset_mid_word();
        do_reset();
        send_half(1'b1, 16'h0000, 16);
        push_word(1'b0, 16'h7E81);
        send_half(1'b0, 16'h7E81, 16);
        send_half(1'b1, 16'hF0F0, 3);
        i2s_bclk = 1'b0;
        repeat (2) @(negedge iclk);
        rst_n = 1'b0;
        @(negedge iclk);
        n_checks++;
        if ({wr_en, wr_addr, wr_data, wr_sel, wr_right, frame_err, dbg_state} !== '0)
            $display("FAIL midreset_outputs: got en=%0b addr=%0d data=%02h sel=%0b right=%0b ferr=%0b state=%0d, required all 0",
                     wr_en, wr_addr, wr_data, wr_sel, wr_right, frame_err, dbg_state);
        else
            n_pass++;
        rst_n    = 1'b1;
        exp_addr = '0;
        ferr_cnt = 0;
        for (int i = 0; i < 5; i++) bit_out(1'b1, 1'b1);
        push_word(1'b0, 16'h3CC3);
        send_half(1'b0, 16'h3CC3, 16);
        push_word(1'b1, 16'h9669);
        send_half(1'b1, 16'h9669, 16);
        drain("midreset");
        check_ferr("midreset", 0);
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        test_reset();
        test_single_frame();
        test_loopback();
        test_wrap();
        test_short_word();
        test_tight_frames();
        test_enable();
        test_reset_mid_word();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
